// File: rtl/dct8x8_2d_stream.sv
// dct8x8_2d_stream: streaming 8x8 two-dimensional DCT.
//   Rows enter on s_data/s_valid/s_ready. Each row goes through a
//   combinational 1-D DCT (row stage) into a two-bank transpose buffer.
//   Columns of the oldest full bank go through a second 1-D DCT (column
//   stage), are rounded/shifted by OUT_SHIFT and leave one column per beat
//   on m_data/m_valid/m_ready, with m_last on column 7.
// Ports:
//   clk, rst_n (synchronous, active-low)
//   s_data[8*IN_W], s_valid, s_ready  : input rows, element c at [c*IN_W +: IN_W]
//   m_data[8*IN_W], m_valid, m_ready  : output columns, element r holds Y[r][c]
//   m_last                            : column-7 beat of each block
//   blk_cnt[16]                       : blocks fully emitted, modulo 2^16
// Also contains dct8_chen: combinational 8-point Chen-style DCT with
// constants cos(k*pi/16)/2 in FRAC fractional bits.

module dct8_chen #(
  parameter int IN_W    = 32,
  parameter int FRAC    = 14,
  parameter int CONST_W = 16
) (
  input  logic [8*IN_W-1:0] x,
  output logic [8*IN_W-1:0] y
);
  localparam int PW = IN_W + CONST_W + 3;

  // Base constants are round(cos(k*pi/16)/2 * 2^14); rescale to FRAC bits.
  function automatic int scale_k(input int base);
    if (FRAC >= 14) return base <<< (FRAC - 14);
    else            return base >>> (14 - FRAC);
  endfunction

  localparam logic signed [CONST_W-1:0] k1 = CONST_W'(scale_k(8035));
  localparam logic signed [CONST_W-1:0] k2 = CONST_W'(scale_k(7568));
  localparam logic signed [CONST_W-1:0] k3 = CONST_W'(scale_k(6811));
  localparam logic signed [CONST_W-1:0] k4 = CONST_W'(scale_k(5793));
  localparam logic signed [CONST_W-1:0] k5 = CONST_W'(scale_k(4551));
  localparam logic signed [CONST_W-1:0] k6 = CONST_W'(scale_k(3135));
  localparam logic signed [CONST_W-1:0] k7 = CONST_W'(scale_k(1598));

  // Full-precision signed product; accumulation happens before the single shift.
  function automatic logic signed [PW-1:0] mul(input logic signed [IN_W-1:0] a,
                                              input logic signed [CONST_W-1:0] k);
    logic signed [PW-1:0] ea;
    logic signed [PW-1:0] ek;
    ea = PW'(a);
    ek = PW'(k);
    return ea * ek;
  endfunction

  logic signed [IN_W-1:0] xv [8];
  logic signed [IN_W-1:0] a [4];
  logic signed [IN_W-1:0] b [4];
  logic signed [IN_W-1:0] c0, c1, c2, c3, e0, e4;
  logic signed [PW-1:0]   acc [8];
  logic signed [PW-1:0]   sh [8];

  // Butterflies (IN_W wrap) followed by constant multiply-accumulate per output.
  always_comb begin
    for (int i = 0; i < 8; i++) xv[i] = $signed(x[i*IN_W +: IN_W]);
    for (int i = 0; i < 4; i++) begin
      a[i] = xv[i] + xv[7-i];
      b[i] = xv[i] - xv[7-i];
    end
    c0 = a[0] + a[3];
    c1 = a[1] + a[2];
    c2 = a[1] - a[2];
    c3 = a[0] - a[3];
    e0 = c0 + c1;
    e4 = c0 - c1;
    acc[0] = mul(e0, k4);
    acc[4] = mul(e4, k4);
    acc[2] = mul(c3, k2) + mul(c2, k6);
    acc[6] = mul(c3, k6) - mul(c2, k2);
    acc[1] = mul(b[0], k1) + mul(b[1], k3) + mul(b[2], k5) + mul(b[3], k7);
    acc[3] = mul(b[0], k3) - mul(b[1], k7) - mul(b[2], k1) - mul(b[3], k5);
    acc[5] = mul(b[0], k5) - mul(b[1], k1) + mul(b[2], k7) + mul(b[3], k3);
    acc[7] = mul(b[0], k7) - mul(b[1], k5) + mul(b[2], k3) - mul(b[3], k1);
    for (int k = 0; k < 8; k++) begin
      sh[k] = acc[k] >>> FRAC;
      y[k*IN_W +: IN_W] = sh[k][IN_W-1:0];
    end
  end
endmodule

module dct8x8_2d_stream #(
  parameter int IN_W      = 32,
  parameter int FRAC      = 14,
  parameter int CONST_W   = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [8*IN_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [8*IN_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [15:0]       blk_cnt
);
  // Half-LSB rounding constant; zero when OUT_SHIFT is zero.
  localparam logic signed [IN_W-1:0] rnd = IN_W'((1 << OUT_SHIFT) >> 1);

  logic [8*IN_W-1:0]      row_dct, col_in, col_dct, col_out;
  logic [IN_W-1:0]        tbuf [2][8][8];
  logic signed [IN_W-1:0] rnd_v [8];
  logic [2:0]             wr_row, rd_col;
  logic [1:0]             full, full_nxt;
  logic                   wr_bank, rd_bank, wr_bank_nxt;
  logic                   accept, load;

  // A full bank is never the write bank, so write and read banks cannot collide.
  assign accept = s_valid & s_ready;
  assign load   = full[rd_bank] & (~m_valid | m_ready);

  dct8_chen #(.IN_W(IN_W), .FRAC(FRAC), .CONST_W(CONST_W)) u_row (
    .x(s_data), .y(row_dct)
  );

  // Gather column rd_col of the read bank for the column stage.
  always_comb begin
    for (int r = 0; r < 8; r++) col_in[r*IN_W +: IN_W] = tbuf[rd_bank][r][rd_col];
  end

  dct8_chen #(.IN_W(IN_W), .FRAC(FRAC), .CONST_W(CONST_W)) u_col (
    .x(col_in), .y(col_dct)
  );

  // Round half up, then arithmetic shift each coefficient.
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      rnd_v[r] = $signed(col_dct[r*IN_W +: IN_W]) + rnd;
      col_out[r*IN_W +: IN_W] = rnd_v[r] >>> OUT_SHIFT;
    end
  end

  // Next bank-full flags and write pointer; fill and release hit different banks.
  always_comb begin
    full_nxt    = full;
    wr_bank_nxt = wr_bank;
    if (accept && (wr_row == 3'd7)) begin
      full_nxt[wr_bank] = 1'b1;
      wr_bank_nxt       = ~wr_bank;
    end else begin
      wr_bank_nxt = wr_bank;
    end
    if (load && (rd_col == 3'd7)) begin
      full_nxt[rd_bank] = 1'b0;
    end else begin
      full_nxt[rd_bank] = full_nxt[rd_bank];
    end
  end

  // Transpose buffer storage; contents are only read from banks marked full.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < 8; c++) tbuf[wr_bank][wr_row][c] <= row_dct[c*IN_W +: IN_W];
    end
  end

  // Pointers, bank flags, output register and block counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_row  <= 3'd0;
      rd_col  <= 3'd0;
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
      blk_cnt <= 16'd0;
    end else begin
      full    <= full_nxt;
      wr_bank <= wr_bank_nxt;
      s_ready <= ~full_nxt[wr_bank_nxt];
      if (accept) wr_row <= wr_row + 3'd1;
      if (load) begin
        rd_col  <= rd_col + 3'd1;
        m_data  <= col_out;
        m_last  <= (rd_col == 3'd7);
        m_valid <= 1'b1;
        if (rd_col == 3'd7) rd_bank <= ~rd_bank;
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      if (m_valid && m_ready && m_last) blk_cnt <= blk_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_dct8x8_2d_stream.sv
module tb_dct8x8_2d_stream;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         m_ready = 1'b0;
  logic         s_ready, m_valid, m_last;
  logic [255:0] m_data;
  logic [15:0]  blk_cnt;
  logic         s_ready2, m_valid2, m_last2;
  logic [255:0] m_data2;
  logic [15:0]  blk_cnt2;

  always #5 clk = ~clk;

  dct8x8_2d_stream #(.IN_W(32), .FRAC(14), .CONST_W(16), .OUT_SHIFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .blk_cnt(blk_cnt)
  );

  dct8x8_2d_stream #(.IN_W(32), .FRAC(14), .CONST_W(16), .OUT_SHIFT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready2),
    .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready), .m_last(m_last2), .blk_cnt(blk_cnt2)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [255:0] q1[$], q2[$], exp1[$], exp2[$], rows_q[$];
  logic         ql[$];
  int           s_acc = 0;
  bit           s_drop = 1'b0;
  longint       mb[8][8], rt[8][8], yt[8][8];

  // Output/input monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin q1.push_back(m_data); ql.push_back(m_last); end
      if (m_valid2 && m_ready) q2.push_back(m_data2);
      if (s_valid && s_ready) s_acc++;
      if (s_valid && !s_ready) s_drop = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic longint cval(input int j);
    case (j)
      1: return 64'sd8035;
      2: return 64'sd7568;
      3: return 64'sd6811;
      4: return 64'sd5793;
      5: return 64'sd4551;
      6: return 64'sd3135;
      7: return 64'sd1598;
      default: return 64'sd0;
    endcase
  endfunction

  // Matrix coefficient: cos((2n+1)k*pi/16)/2, with k=0 scaled by 1/sqrt(2).
  function automatic longint mcoef(input int k, input int n);
    int j;
    longint s;
    if (k == 0) return 64'sd5793;
    j = ((2*n + 1) * k) % 32;
    s = 1;
    if (j > 16) j = 32 - j;
    if (j > 8) begin s = -1; j = 16 - j; end
    return s * cval(j);
  endfunction

  function automatic int pat(input int kind, input int b, input int r, input int c);
    case (kind)
      0: return 0;
      1: return 100;
      3: return -100;
      default: return ((r*8 + c)*37 + b*53 + r*c*5) % 211 - 105;
    endcase
  endfunction

  // Generate one block of rows and its expected columns (direct matrix sums).
  task automatic push_block(input int kind, input int b);
    logic [255:0] v, v2;
    longint acc;
    int y;
    for (int r = 0; r < 8; r++) begin
      v = '0;
      for (int c = 0; c < 8; c++) begin
        mb[r][c] = pat(kind, b, r, c);
        v[c*32 +: 32] = pat(kind, b, r, c);
      end
      rows_q.push_back(v);
    end
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) begin
        acc = 0;
        for (int n = 0; n < 8; n++) acc += mb[r][n] * mcoef(k, n);
        rt[r][k] = longint'(int'(acc >>> 14));
      end
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 8; k++) begin
        acc = 0;
        for (int n = 0; n < 8; n++) acc += rt[n][c] * mcoef(k, n);
        yt[k][c] = longint'(int'(acc >>> 14));
      end
    for (int c = 0; c < 8; c++) begin
      v = '0; v2 = '0;
      for (int r = 0; r < 8; r++) begin
        y = int'(yt[r][c]);
        v[r*32 +: 32]  = y;
        v2[r*32 +: 32] = (y + 2) >>> 2;
      end
      exp1.push_back(v);
      exp2.push_back(v2);
    end
  endtask

  task automatic stream_rows(input int n);
    int t;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      s_data  = rows_q.pop_front();
      s_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!s_ready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) check32("row_accept_timeout", 32'(s_ready), 32'd1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int t;
    t = 0;
    while (q1.size() < n && t < 500) begin @(negedge clk); t++; end
    repeat (6) @(negedge clk);
  endtask

  task automatic compare_all(input string tag, input int n);
    logic [255:0] o, e;
    logic         l;
    check32({tag, "_count"}, q1.size(), n);
    check32({tag, "_count_sh"}, q2.size(), n);
    for (int i = 0; i < n; i++) begin
      o = (q1.size() > 0) ? q1.pop_front() : 'x;
      l = (ql.size() > 0) ? ql.pop_front() : 1'bx;
      e = exp1.pop_front();
      check({tag, $sformatf("_col%0d", i)}, o, e);
      check32({tag, $sformatf("_last%0d", i)}, 32'(l), ((i % 8) == 7) ? 32'd1 : 32'd0);
      o = (q2.size() > 0) ? q2.pop_front() : 'x;
      e = exp2.pop_front();
      check({tag, $sformatf("_shcol%0d", i)}, o, e);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q1.delete(); q2.delete(); ql.delete();
    exp1.delete(); exp2.delete(); rows_q.delete();
    s_acc = 0; s_drop = 1'b0;
  endtask

  initial begin
    logic [255:0] held;
    logic         hl;
    bit           stable;
    int           t;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_m_valid", 32'(m_valid), 32'd0);
    check32("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", m_data, 256'd0);
    check32("rst_blk_cnt", 32'(blk_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check32("rst_s_ready", 32'(s_ready), 32'd1);

    // All-zero block
    m_ready = 1'b1;
    push_block(0, 0);
    stream_rows(8);
    wait_beats(8);
    compare_all("zero", 8);
    check32("zero_blk_cnt", 32'(blk_cnt), 32'd1);

    // DC block with latency and hand-computed DC term
    push_block(1, 0);
    stream_rows(8);
    check32("dc_not_early", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    check32("dc_valid_e1", 32'(m_valid), 32'd1);
    check32("dc_y00", m_data[31:0], 32'd797);
    check32("dc_y10", m_data[63:32], 32'd0);
    check32("dc_y00_sh", m_data2[31:0], 32'd199);
    wait_beats(8);
    compare_all("dc", 8);

    // Negative DC block for shift rounding
    push_block(3, 0);
    stream_rows(8);
    wait_beats(8);
    check32("neg_y00", q1[0][31:0], -32'sd801);
    check32("neg_y00_sh", q2[0][31:0], -32'sd200);
    compare_all("neg", 8);
    check32("neg_blk_cnt", 32'(blk_cnt), 32'd3);

    // Back-to-back: 4 blocks streamed continuously
    do_reset();
    for (int b = 0; b < 4; b++) push_block(2, b);
    m_ready = 1'b1;
    stream_rows(32);
    wait_beats(32);
    compare_all("b2b", 32);
    check32("b2b_no_sready_drop", 32'(s_drop), 32'd0);
    check32("b2b_blk_cnt", 32'(blk_cnt), 32'd4);

    // Backpressure: m_ready low for 20 cycles after first m_valid
    do_reset();
    m_ready = 1'b0;
    for (int b = 0; b < 3; b++) push_block(2, b + 5);
    fork
      stream_rows(24);
      begin
        t = 0;
        @(negedge clk);
        while (!m_valid && t < 100) begin @(negedge clk); t++; end
        held = m_data; hl = m_last; stable = 1'b1;
        repeat (20) begin
          @(negedge clk);
          if (m_data !== held || m_valid !== 1'b1 || m_last !== hl) stable = 1'b0;
        end
        check32("bp_stable", 32'(stable), 32'd1);
        check32("bp_s_ready_low", 32'(s_ready), 32'd0);
        check32("bp_rows_accepted", s_acc, 32'd16);
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    wait_beats(24);
    compare_all("bp", 24);
    check32("bp_blk_cnt", 32'(blk_cnt), 32'd3);

    // Reset mid-block with a full bank and a partial bank pending
    do_reset();
    m_ready = 1'b0;
    push_block(2, 10);
    stream_rows(8);
    push_block(2, 11);
    stream_rows(6);
    repeat (2) @(posedge clk);
    #1;
    check32("mid_pending_valid", 32'(m_valid), 32'd1);
    do_reset();
    m_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check32("mid_no_output", q1.size(), 32'd0);
    check32("mid_m_valid", 32'(m_valid), 32'd0);
    check32("mid_blk_cnt_zero", 32'(blk_cnt), 32'd0);
    push_block(2, 12);
    stream_rows(8);
    wait_beats(8);
    compare_all("mid_after", 8);
    check32("mid_blk_cnt", 32'(blk_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dct8x8_2d_stream.md
DCT8X8_2D_STREAM -- requirements
Module: dct8x8_2d_stream

Interface
REQ-001 The module SHALL have parameter IN_W, default 32: sample width in bits, two's complement.
REQ-002 The module SHALL have parameter FRAC, default 14: fractional bits of the DCT constants, passed unchanged to dct8_chen.
REQ-003 The module SHALL have parameter CONST_W, default 16: DCT constant width, passed unchanged to dct8_chen.
REQ-004 The module SHALL have parameter OUT_SHIFT, default 0: arithmetic right shift applied to every output coefficient, rounding half up.
REQ-005 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The module SHALL have port s_data, input, 8*IN_W bits: one input row; element c at [c*IN_W +: IN_W].
REQ-008 The module SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-009 The module SHALL have port s_ready, output, 1 bit: the row is accepted when s_valid and s_ready are both 1.
REQ-010 The module SHALL have port m_data, output, 8*IN_W bits: one output column c; element r at [r*IN_W +: IN_W] holds Y[r][c].
REQ-011 The module SHALL have port m_valid, output, 1 bit: m_data is valid.
REQ-012 The module SHALL have port m_ready, input, 1 bit: the column is consumed when m_valid and m_ready are both 1.
REQ-013 The module SHALL have port m_last, output, 1 bit: 1 on the column-7 beat of each block.
REQ-014 The module SHALL have port blk_cnt, output, 16 bits: count of blocks fully emitted, modulo 2^16.

Function
REQ-015 Rows SHALL pass through one combinational dct8_chen instance (row stage), and the result SHALL be written into the write bank of a two-bank 8x8 transpose buffer at row index wr_row.
REQ-016 wr_row SHALL increment on each accepted row and wrap from 7 to 0. On that wrap the write bank SHALL be marked full and the write pointer SHALL toggle to the other bank.
REQ-017 s_ready SHALL be 1 exactly when the current write bank is not full.
REQ-018 A second dct8_chen instance (column stage) SHALL read column rd_col of the oldest full bank, i.e. row_dct[0..7][rd_col].
REQ-019 The column-stage result SHALL be shifted per OUT_SHIFT and loaded into the m_data register.
REQ-020 The output register SHALL load when a full bank exists and either m_valid=0 or m_ready=1, which is a one-deep skid-free pipeline.
REQ-021 rd_col SHALL increment on each load. When it wraps 7->0, the read bank SHALL be released (marked not full) in the same cycle and the read pointer SHALL toggle.
REQ-022 When m_valid=1 and m_ready=0, m_data, m_last and m_valid SHALL hold stable.
REQ-023 Latency: if the row-7 handshake occurs at edge E, column 0 SHALL be valid after edge E+1.
REQ-024 With s_valid=1 and m_ready=1 held continuously, throughput SHALL be one row in and one column out per cycle, and s_ready SHALL never drop.
REQ-025 When both banks are full, s_ready SHALL be 0.
REQ-026 When a bank release and a row-7 write to the other bank occur in the same cycle, both SHALL take effect, with no lost block and no duplicated block.
REQ-027 A bank write and a read of the other bank SHALL never target the same bank.
REQ-028 Internal arithmetic widths SHALL be IN_W, as in dct8_chen; overflow SHALL wrap.
REQ-029 The rounding add for OUT_SHIFT>0 SHALL be 1<<(OUT_SHIFT-1); with OUT_SHIFT=0 the data SHALL pass unchanged.
REQ-030 blk_cnt SHALL increment on the m_last handshake and wrap from 0xFFFF to 0.

Reset
REQ-031 While rst_n=0 at a rising edge, the following SHALL be cleared: wr_row, rd_col, both bank-full flags, both bank pointers, m_valid, m_last, m_data and blk_cnt.
REQ-032 s_ready SHALL be 1 in the first cycle after reset is released.
REQ-033 A reset applied mid-block SHALL discard all partial and full banks. No column of a discarded block SHALL appear after reset.
REQ-034 Transpose-buffer contents need not be cleared, and SHALL never be observable before being rewritten.

Verification
REQ-035 Bench scenario, all-zero block: 8 zero rows with m_ready=1 -> 8 beats of m_data=0, m_last=1 on beat 8 only, blk_cnt=1.
REQ-036 Bench scenario, DC block (all samples 100, OUT_SHIFT=0): m_data SHALL equal a bit-exact row-then-column dct8_chen model, with only Y[0][0] nonzero within model tolerance, and column 0 valid at E+1.
REQ-037 Bench scenario, back-to-back: 4 blocks, 32 rows streamed with m_ready=1 -> s_ready constantly 1, 32 columns out in order, blk_cnt=4.
REQ-038 Bench scenario, backpressure: m_ready=0 for 20 cycles after first m_valid -> m_data stable, s_ready falls after 16 rows accepted, and all columns are delivered intact when m_ready returns to 1.
REQ-039 Bench scenario, reset mid-block: reset after row 5 of block 2 -> no output from block 2, and the next full block is output correctly with blk_cnt restarting at 0.
REQ-040 Bench scenario, OUT_SHIFT=2: every coefficient SHALL equal (model+2)>>>2, including for negative values.
